// File: rtl/ddr2_cmp_rd_data_chk_if.sv
// ddr2_cmp_rd_data_chk_if: read-beat, compare and status signals of the DDR2 read-data checker.
interface ddr2_cmp_rd_data_chk_if #(
    parameter int DQ_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
);
    localparam int NB = DQ_WIDTH / 8;
    logic                  read_data_valid;
    logic [2*DQ_WIDTH-1:0] read_data_fifo_out;
    logic [2*DQ_WIDTH-1:0] app_compare_data;
    logic [NB-1:0]         byte_mask;
    logic                  clr_err;
    logic                  error;
    logic                  error_pulse;
    logic [NB-1:0]         byte_err_rise;
    logic [NB-1:0]         byte_err_fall;
    logic [CNT_WIDTH-1:0]  beat_count;
    logic [CNT_WIDTH-1:0]  err_count;
    logic [2*DQ_WIDTH-1:0] first_err_rd_data;
    logic [2*DQ_WIDTH-1:0] first_err_exp_data;
    logic [CNT_WIDTH-1:0]  first_err_beat;
    modport master (
        output read_data_valid, read_data_fifo_out, app_compare_data, byte_mask, clr_err,
        input  error, error_pulse, byte_err_rise, byte_err_fall, beat_count, err_count,
               first_err_rd_data, first_err_exp_data, first_err_beat
    );
    modport slave (
        input  read_data_valid, read_data_fifo_out, app_compare_data, byte_mask, clr_err,
        output error, error_pulse, byte_err_rise, byte_err_fall, beat_count, err_count,
               first_err_rd_data, first_err_exp_data, first_err_beat
    );
endinterface

// File: rtl/ddr2_cmp_rd_data_chk.sv
// ddr2_cmp_rd_data_chk: 3-stage read-beat checker with sticky byte masks and saturating counters.
// Define CMP_FIRST_ERR_CAPTURE_EN to latch the first erroring beat and its index.
module ddr2_cmp_rd_data_chk #(
    parameter int DQ_WIDTH    = 32,
    parameter int CNT_WIDTH   = 16,
    parameter int STOP_ON_ERR = 0
) (
    input logic clk,
    input logic reset,
    ddr2_cmp_rd_data_chk_if.slave bus
);
    localparam int NB = DQ_WIDTH / 8;
    localparam int W  = 2 * DQ_WIDTH;
    logic                 reset_r, v1, v2, beat_err, err_b, bc_inc, ec_inc;
    logic [W-1:0]         rd1, ex1;
    logic [NB-1:0]        m1, mr, mf, mis_rise, mis_fall, br_b, bf_b;
    logic [CNT_WIDTH-1:0] bc_b, ec_b;
    // Upper half of each beat is the rising-edge data, lower half the falling-edge data.
    for (genvar b = 0; b < NB; b++) begin : g_byte
        assign mr[b] = v1 & ~m1[b] & (rd1[DQ_WIDTH+8*b +: 8] != ex1[DQ_WIDTH+8*b +: 8]);
        assign mf[b] = v1 & ~m1[b] & (rd1[8*b +: 8] != ex1[8*b +: 8]);
    end
    // clr_err zeroes the base state; the beat in S3 is then merged on top of it.
    always_comb begin
        beat_err = |mis_rise | |mis_fall;
        err_b    = bus.clr_err ? 1'b0 : bus.error;
        br_b     = bus.clr_err ? '0 : bus.byte_err_rise;
        bf_b     = bus.clr_err ? '0 : bus.byte_err_fall;
        bc_b     = bus.clr_err ? '0 : bus.beat_count;
        ec_b     = bus.clr_err ? '0 : bus.err_count;
        bc_inc   = v2 & ~&bc_b & ~((STOP_ON_ERR != 0) & err_b);
        ec_inc   = beat_err & ~&ec_b;
    end
    always_ff @(posedge clk) begin
        reset_r <= reset;
        rd1     <= bus.read_data_fifo_out;
        ex1     <= bus.app_compare_data;
        m1      <= bus.byte_mask;
        if (reset_r) begin
            v1                <= 1'b0;
            v2                <= 1'b0;
            mis_rise          <= '0;
            mis_fall          <= '0;
            bus.error         <= 1'b0;
            bus.error_pulse   <= 1'b0;
            bus.byte_err_rise <= '0;
            bus.byte_err_fall <= '0;
            bus.beat_count    <= '0;
            bus.err_count     <= '0;
        end else begin
            v1                <= bus.read_data_valid;
            v2                <= v1;
            mis_rise          <= mr;
            mis_fall          <= mf;
            bus.error         <= err_b | beat_err;
            bus.error_pulse   <= beat_err;
            bus.byte_err_rise <= br_b | mis_rise;
            bus.byte_err_fall <= bf_b | mis_fall;
            bus.beat_count    <= bc_b + CNT_WIDTH'(bc_inc);
            bus.err_count     <= ec_b + CNT_WIDTH'(ec_inc);
        end
    end
`ifdef CMP_FIRST_ERR_CAPTURE_EN
    logic [W-1:0] rd2, ex2;
    always_ff @(posedge clk) begin
        rd2 <= rd1;
        ex2 <= ex1;
        if (reset_r) begin
            bus.first_err_rd_data  <= '0;
            bus.first_err_exp_data <= '0;
            bus.first_err_beat     <= '0;
        end else if (beat_err && !err_b) begin
            bus.first_err_rd_data  <= rd2;
            bus.first_err_exp_data <= ex2;
            bus.first_err_beat     <= bc_b;
        end else if (bus.clr_err) begin
            bus.first_err_rd_data  <= '0;
            bus.first_err_exp_data <= '0;
            bus.first_err_beat     <= '0;
        end
    end
`else
    assign bus.first_err_rd_data  = '0;
    assign bus.first_err_exp_data = '0;
    assign bus.first_err_beat     = '0;
`endif
endmodule
